// File: rtl/mem_pkg.sv
// Shared constants for the memory responder and its neighbours (memory-access
// FSM, MAR, MDR): FSM state encoding, RW polarity and default bus widths.
package mem_pkg;

  localparam int unsigned ADDR_W    = 8;   // low address bits decoded by the array
  localparam int unsigned DATA_W    = 16;  // word width, matches MDR
  localparam int unsigned ADDR_IN_W = 16;  // full MAR width seen on the bus
  localparam int unsigned CNT_W     = 4;   // latency counter width (0..15)
  localparam int unsigned ST_W      = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_WAIT = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage : mem_pkg

// File: rtl/mem_responder_if.sv
// Load/store handshake between the memory-access FSM (master) and the memory
// responder (slave).
//   memEN  : request strobe, level-held for the whole access
//   RW     : 1 = load, 0 = store
//   addr   : word address from MAR
//   wdata  : store data from MDR
//   rdata  : load data returned to MDR
//   MFC    : memory-function-complete, held until memEN drops
//   busy   : responder has an access in flight or completed
interface mem_responder_if
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = mem_pkg::DATA_W
);

  logic                 memEN;
  logic                 RW;
  logic [ADDR_IN_W-1:0] addr;
  logic [DATA_W-1:0]    wdata;
  logic [DATA_W-1:0]    rdata;
  logic                 MFC;
  logic                 busy;

  modport master (
    output memEN, RW, addr, wdata,
    input  rdata, MFC, busy
  );

  modport slave (
    input  memEN, RW, addr, wdata,
    output rdata, MFC, busy
  );

endinterface : mem_responder_if

// File: rtl/mem_array.sv
// Single-port synchronous RAM, DATA_W x 2**ADDR_W, registered read port.
//   clk, rst : clock; rst clears only the read register, never the contents
//   i_we     : write i_wdata to i_addr on this edge
//   i_re     : load the read register from i_addr on this edge
//   i_addr   : word address
//   i_wdata  : write data
//   o_rdata  : read register, holds its value between read strobes
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage: no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Read register: only a read strobe changes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : mem_array

// File: rtl/mem_responder.sv
// Memory-side responder for the load/store handshake. Latches a request when
// memEN is seen high in IDLE, waits LATENCY cycles, performs the access against
// mem_array and raises MFC until the initiator drops memEN. Dropping memEN
// during the wait aborts the access with no side effects.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of mem_responder_if (memEN/RW/addr/wdata in,
//              rdata/MFC/busy out)
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = mem_pkg::ADDR_W,
  parameter int unsigned DATA_W  = mem_pkg::DATA_W,
  parameter int unsigned LATENCY = 3
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  logic [ST_W-1:0]   r_state;
  logic [ST_W-1:0]   w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              r_rw;
  logic              w_rw_nxt;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] w_wdata_nxt;
  logic              r_mfc;
  logic              r_busy;
  logic              w_we;
  logic              w_re;
  logic              w_unused_addr;

  // Upper MAR bits are deliberately ignored; the array wraps.
  assign w_unused_addr = ^bus.addr[ADDR_IN_W-1:ADDR_W];

  // State, latched request and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_rw    <= RW_WRITE;
      r_wdata <= '0;
      r_mfc   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_rw    <= w_rw_nxt;
      r_wdata <= w_wdata_nxt;
      // Registered decode of the next state so MFC/busy track r_state exactly.
      r_mfc   <= (w_state_nxt == ST_DONE);
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Next-state, request latch and array strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_rw_nxt    = r_rw;
    w_wdata_nxt = r_wdata;
    w_we        = 1'b0;
    w_re        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.memEN) begin
          w_addr_nxt  = bus.addr[ADDR_W-1:0];
          w_rw_nxt    = bus.RW;
          w_wdata_nxt = bus.wdata;
          w_cnt_nxt   = CNT_W'(LATENCY);
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!bus.memEN) begin
          // Abort: nothing touches the array or rdata.
          w_state_nxt = ST_IDLE;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_state_nxt = ST_DONE;
          if (r_rw == RW_READ) begin
            w_re = 1'b1;
          end else begin
            w_we = 1'b1;
          end
        end
      end
      ST_DONE: begin
        // Leaving DONE only on memEN low guarantees the low sample a new request needs.
        if (!bus.memEN) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The array's read register is the rdata output register.
  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (bus.rdata)
  );

  assign bus.MFC  = r_mfc;
  assign bus.busy = r_busy;

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with LATENCY=3 (index 0) and one with
// LATENCY=0 (index 1). A reference array per instance predicts load data;
// expected load data is queued when a load is issued and popped when MFC rises.
module tb_mem_responder;
  import mem_pkg::*;

  logic clk;
  logic rst;

  logic        r_en    [2];
  logic        r_rw    [2];
  logic [15:0] r_addr  [2];
  logic [15:0] r_wdata [2];
  logic        w_mfc   [2];
  logic        w_busy  [2];
  logic [15:0] w_rdata [2];

  logic [15:0] mdl [2][256];
  logic [15:0] exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  mem_responder_if #(.DATA_W(16)) if3 ();
  mem_responder_if #(.DATA_W(16)) if0 ();

  assign if3.memEN = r_en[0];
  assign if3.RW    = r_rw[0];
  assign if3.addr  = r_addr[0];
  assign if3.wdata = r_wdata[0];
  assign w_mfc[0]   = if3.MFC;
  assign w_busy[0]  = if3.busy;
  assign w_rdata[0] = if3.rdata;

  assign if0.memEN = r_en[1];
  assign if0.RW    = r_rw[1];
  assign if0.addr  = r_addr[1];
  assign if0.wdata = r_wdata[1];
  assign w_mfc[1]   = if0.MFC;
  assign w_busy[1]  = if0.busy;
  assign w_rdata[1] = if0.rdata;

  mem_responder #(.ADDR_W(8), .DATA_W(16), .LATENCY(3)) dut3 (
    .clk (clk), .rst (rst), .bus (if3.slave)
  );

  mem_responder #(.ADDR_W(8), .DATA_W(16), .LATENCY(0)) dut0 (
    .clk (clk), .rst (rst), .bus (if0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Full access. Called just after a posedge; returns just after a posedge
  // with memEN low and the responder back in IDLE.
  task automatic access(input int d, input logic rw, input logic [15:0] a,
                        input logic [15:0] wd, input int hold, input bit scramble);
    int lat;
    logic [15:0] e;
    lat = (d == 0) ? 3 : 0;
    r_en[d] = 1'b1; r_rw[d] = rw; r_addr[d] = a; r_wdata[d] = wd;
    e = 16'h0;
    if (rw == RW_READ) exp_q.push_back(mdl[d][a[7:0]]);
    else mdl[d][a[7:0]] = wd;
    @(posedge clk); #1;
    check("accept_busy", 32'(w_busy[d]), 32'd1);
    check("accept_mfc", 32'(w_mfc[d]), 32'd0);
    if (scramble) begin
      r_rw[d] = ~rw; r_addr[d] = a + 16'h0001; r_wdata[d] = ~wd;
    end
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      check("wait_mfc_low", 32'(w_mfc[d]), 32'd0);
    end
    @(posedge clk); #1;
    check("mfc_rise", 32'(w_mfc[d]), 32'd1);
    if (rw == RW_READ) begin
      if (exp_q.size() == 0) begin
        check("queue_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("rdata_done", 32'(w_rdata[d]), 32'(e));
      end
    end
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      check("mfc_held", 32'(w_mfc[d]), 32'd1);
      check("busy_held", 32'(w_busy[d]), 32'd1);
    end
    r_en[d] = 1'b0;
    @(posedge clk); #1;
    check("drop_mfc", 32'(w_mfc[d]), 32'd0);
    check("drop_busy", 32'(w_busy[d]), 32'd0);
    if (rw == RW_READ) check("rdata_after", 32'(w_rdata[d]), 32'(e));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      r_en[d] = 1'b1; r_rw[d] = RW_WRITE; r_addr[d] = 16'h0; r_wdata[d] = 16'h0;
    end
    // Reset with memEN high on both instances.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_mfc", 32'(w_mfc[d]), 32'd0);
      check("rst_busy", 32'(w_busy[d]), 32'd0);
      check("rst_rdata", 32'(w_rdata[d]), 32'h0);
    end
    rst = 1'b0;
    r_en[1] = 1'b0;

    // Store then load, accepted on the first edge after release.
    access(0, RW_WRITE, 16'h0012, 16'hBEEF, 0, 1'b0);
    access(0, RW_READ,  16'h0012, 16'h0000, 0, 1'b0);

    // Address wrap: 0x0105 and 0x0005 hit the same word.
    access(0, RW_WRITE, 16'h0105, 16'h1234, 0, 1'b0);
    access(0, RW_READ,  16'h0005, 16'h0000, 0, 1'b0);

    // Abort a store to addr 7 after two WAIT cycles.
    access(0, RW_WRITE, 16'h0007, 16'h0707, 0, 1'b0);
    r_en[0] = 1'b1; r_rw[0] = RW_WRITE; r_addr[0] = 16'h0007; r_wdata[0] = 16'hAAAA;
    @(posedge clk);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_mfc_wait", 32'(w_mfc[0]), 32'd0);
    r_en[0] = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 32'(w_busy[0]), 32'd0);
    check("abort_mfc", 32'(w_mfc[0]), 32'd0);
    check("abort_rdata", 32'(w_rdata[0]), 32'h1234);
    access(0, RW_READ, 16'h0007, 16'h0000, 0, 1'b0);

    // Held memEN with inputs changed during WAIT: only the latched store happens.
    access(0, RW_WRITE, 16'h0021, 16'h2121, 0, 1'b0);
    access(0, RW_WRITE, 16'h0020, 16'hC0DE, 10, 1'b1);
    @(posedge clk); #1;
    check("idle_busy", 32'(w_busy[0]), 32'd0);
    access(0, RW_READ, 16'h0020, 16'h0000, 0, 1'b0);
    access(0, RW_READ, 16'h0021, 16'h0000, 0, 1'b0);

    // Held load keeps MFC and rdata.
    access(0, RW_READ, 16'h0012, 16'h0000, 3, 1'b0);

    // Zero-latency instance.
    access(1, RW_WRITE, 16'h0040, 16'h9999, 0, 1'b0);
    access(1, RW_READ,  16'h0040, 16'h0000, 2, 1'b0);
    access(1, RW_READ,  16'h0012, 16'h0000, 0, 1'b1);

    // Reset during WAIT of a store: pending write is discarded.
    access(0, RW_WRITE, 16'h0003, 16'h1111, 0, 1'b0);
    r_en[0] = 1'b1; r_rw[0] = RW_WRITE; r_addr[0] = 16'h0003; r_wdata[0] = 16'h5555;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_busy", 32'(w_busy[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_mfc", 32'(w_mfc[0]), 32'd0);
    check("midrst_busy", 32'(w_busy[0]), 32'd0);
    check("midrst_rdata", 32'(w_rdata[0]), 32'h0);
    r_en[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    access(0, RW_READ, 16'h0003, 16'h0000, 0, 1'b0);
    access(0, RW_READ, 16'h0105, 16'h0000, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mem_responder
